// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the LCD text responder.
package lcd_pkg;

  localparam int LINE_LEN  = 16;
  localparam int BUF_DEPTH = 32;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  // Post-transfer wait selection handed to the nibble writer.
  localparam logic [1:0] POST_LONG  = 2'd0;
  localparam logic [1:0] POST_SHORT = 2'd1;
  localparam logic [1:0] POST_CMD   = 2'd2;
  localparam logic [1:0] POST_CLEAR = 2'd3;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_CFG,
    S_ADDR1,
    S_LINE1,
    S_ADDR2,
    S_LINE2
  } main_state_e;

  // Configuration command issued at each step of S_CFG.
  function automatic logic [7:0] cfg_byte(input logic [1:0] step);
    case (step)
      2'd0:    cfg_byte = CMD_FUNC_SET;
      2'd1:    cfg_byte = CMD_ENTRY;
      2'd2:    cfg_byte = CMD_DISP_ON;
      default: cfg_byte = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one nibble or one byte (two nibbles) onto the 4-bit LCD bus with
// setup, enable pulse, hold, inter-nibble gap and a selectable post wait.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_INIT_LONG  = 205000,
  parameter int T_INIT_SHORT = 5000,
  parameter int T_CMD        = 2000,
  parameter int T_CLEAR      = 82000,
  parameter int T_E          = 12,
  parameter int T_SETUP      = 2,
  parameter int T_NIB_GAP    = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       byte_mode,
  input  logic       rs,
  input  logic [7:0] value,
  input  logic [1:0] post_sel,
  output logic       busy,
  output logic [3:0] sf_d,
  output logic       lcd_e,
  output logic       lcd_rs
);

  typedef enum logic [2:0] {W_IDLE, W_SETUP, W_EHIGH, W_HOLD, W_GAP, W_POST} wr_state_e;

  wr_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] post_cnt;
  logic [3:0]  lo_q, lo_d;
  logic        pend_q, pend_d;
  logic [1:0]  post_q, post_d;
  logic [3:0]  sf_d_q, sf_d_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;

  // Reload value for the wait that follows the last nibble.
  always_comb begin
    case (post_q)
      POST_LONG:  post_cnt = 32'(T_INIT_LONG - 1);
      POST_SHORT: post_cnt = 32'(T_INIT_SHORT - 1);
      POST_CMD:   post_cnt = 32'(T_CMD - 1);
      default:    post_cnt = 32'(T_CLEAR - 1);
    endcase
  end

  // Transfer sequencer; every counter runs down to zero and then moves on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    post_d  = post_q;
    sf_d_d  = sf_d_q;
    e_d     = e_q;
    rs_d    = rs_q;
    case (state_q)
      W_IDLE: if (start) begin
        rs_d    = rs;
        post_d  = post_sel;
        lo_d    = value[3:0];
        pend_d  = byte_mode;
        sf_d_d  = byte_mode ? value[7:4] : value[3:0];
        cnt_d   = 32'(T_SETUP - 1);
        state_d = W_SETUP;
      end
      W_SETUP: if (cnt_q == '0) begin
        e_d     = 1'b1;
        cnt_d   = 32'(T_E - 1);
        state_d = W_EHIGH;
      end else cnt_d = cnt_q - 32'd1;
      W_EHIGH: if (cnt_q == '0) begin
        e_d     = 1'b0;
        state_d = W_HOLD;
      end else cnt_d = cnt_q - 32'd1;
      // Data and RS stay put for this one cycle with lcd_e low.
      W_HOLD: if (pend_q) begin
        pend_d  = 1'b0;
        cnt_d   = 32'(T_NIB_GAP - 1);
        state_d = W_GAP;
      end else begin
        cnt_d   = post_cnt;
        state_d = W_POST;
      end
      W_GAP: if (cnt_q == '0) begin
        sf_d_d  = lo_q;
        cnt_d   = 32'(T_SETUP - 1);
        state_d = W_SETUP;
      end else cnt_d = cnt_q - 32'd1;
      W_POST: if (cnt_q == '0) state_d = W_IDLE;
              else cnt_d = cnt_q - 32'd1;
      default: state_d = W_IDLE;
    endcase
  end

  // Registered bus outputs; reset drops lcd_e immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      pend_q  <= 1'b0;
      post_q  <= POST_CMD;
      sf_d_q  <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      post_q  <= post_d;
      sf_d_q  <= sf_d_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
    end
  end

  assign busy   = (state_q != W_IDLE);
  assign sf_d   = sf_d_q;
  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;

endmodule

// File: rtl/lcd_text_responder.sv
// Character buffer with a host write/read port and a free-running refresh
// engine that initialises an HD44780 panel and then streams both lines.
module lcd_text_responder
  import lcd_pkg::*;
#(
  parameter int T_POWERUP    = 750000,
  parameter int T_INIT_LONG  = 205000,
  parameter int T_INIT_SHORT = 5000,
  parameter int T_CMD        = 2000,
  parameter int T_CLEAR      = 82000,
  parameter int T_E          = 12,
  parameter int T_SETUP      = 2,
  parameter int T_NIB_GAP    = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       write_enable,
  input  logic [4:0] location,
  input  logic [7:0] data,
  output logic [7:0] read_data,
  output logic       ready,
  output logic [3:0] sf_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);

  logic [BUF_DEPTH-1:0][7:0] buf_q, buf_d;

  main_state_e state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [3:0]  idx_q, idx_d;
  logic        launched_q, launched_d;
  logic        start_q, start_d;
  logic        bmode_q, bmode_d;
  logic        nrs_q, nrs_d;
  logic [7:0]  val_q, val_d;
  logic [1:0]  post_q, post_d;
  logic [31:0] wait_q, wait_d;
  logic        ready_q, ready_d;
  logic        item_done;
  logic        wr_busy;

  // Host writes land unconditionally, whatever the refresh engine is doing.
  always_comb begin
    buf_d = buf_q;
    if (write_enable) buf_d[location] = data;
  end

  // Buffer storage, cleared to spaces on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= {BUF_DEPTH{CHAR_SPACE}};
    else        buf_q <= buf_d;
  end

  assign read_data = buf_q[location];

  // Sequencer: launch one item, wait for the writer to finish, advance.
  // The refresh character is sampled from the buffer at launch time.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    idx_d      = idx_q;
    launched_d = launched_q;
    start_d    = 1'b0;
    bmode_d    = bmode_q;
    nrs_d      = nrs_q;
    val_d      = val_q;
    post_d     = post_q;
    wait_d     = wait_q;
    ready_d    = ready_q;
    // start_q is still in flight for one cycle before busy rises
    item_done  = launched_q && !start_q && !wr_busy;
    if (state_q == S_POWERUP) begin
      if (!launched_q) begin
        wait_d     = 32'(T_POWERUP - 1);
        launched_d = 1'b1;
      end else if (wait_q == '0) begin
        launched_d = 1'b0;
        step_d     = 2'd0;
        state_d    = S_INIT;
      end else wait_d = wait_q - 32'd1;
    end else if (!launched_q) begin
      if (!wr_busy) begin
        start_d    = 1'b1;
        launched_d = 1'b1;
        bmode_d    = 1'b1;
        nrs_d      = 1'b0;
        post_d     = POST_CMD;
        case (state_q)
          S_INIT: begin
            bmode_d = 1'b0;
            val_d   = {4'h0, (step_q == 2'd3) ? 4'h2 : 4'h3};
            if (step_q == 2'd0)      post_d = POST_LONG;
            else if (step_q == 2'd1) post_d = POST_SHORT;
          end
          S_CFG: begin
            val_d = cfg_byte(step_q);
            if (step_q == 2'd3) post_d = POST_CLEAR;
          end
          S_ADDR1: val_d = CMD_LINE1;
          S_ADDR2: val_d = CMD_LINE2;
          S_LINE1: begin nrs_d = 1'b1; val_d = buf_q[{1'b0, idx_q}]; end
          S_LINE2: begin nrs_d = 1'b1; val_d = buf_q[{1'b1, idx_q}]; end
          default: ;
        endcase
      end
    end else if (item_done) begin
      launched_d = 1'b0;
      case (state_q)
        S_INIT: if (step_q == 2'd3) begin step_d = 2'd0; state_d = S_CFG; end
                else step_d = step_q + 2'd1;
        S_CFG: if (step_q == 2'd3) begin
          step_d  = 2'd0;
          ready_d = 1'b1;
          state_d = S_ADDR1;
        end else step_d = step_q + 2'd1;
        S_ADDR1: state_d = S_LINE1;
        S_LINE1: begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(LINE_LEN - 1)) state_d = S_ADDR2;
        end
        S_ADDR2: state_d = S_LINE2;
        S_LINE2: begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(LINE_LEN - 1)) state_d = S_ADDR1;
        end
        default: state_d = S_POWERUP;
      endcase
    end
  end

  // Main FSM registers; reset restarts the whole init sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_POWERUP;
      step_q     <= '0;
      idx_q      <= '0;
      launched_q <= 1'b0;
      start_q    <= 1'b0;
      bmode_q    <= 1'b0;
      nrs_q      <= 1'b0;
      val_q      <= '0;
      post_q     <= POST_CMD;
      wait_q     <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      launched_q <= launched_d;
      start_q    <= start_d;
      bmode_q    <= bmode_d;
      nrs_q      <= nrs_d;
      val_q      <= val_d;
      post_q     <= post_d;
      wait_q     <= wait_d;
      ready_q    <= ready_d;
    end
  end

  lcd_nibble_writer #(
    .T_INIT_LONG (T_INIT_LONG),
    .T_INIT_SHORT(T_INIT_SHORT),
    .T_CMD       (T_CMD),
    .T_CLEAR     (T_CLEAR),
    .T_E         (T_E),
    .T_SETUP     (T_SETUP),
    .T_NIB_GAP   (T_NIB_GAP)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_q),
    .byte_mode(bmode_q),
    .rs       (nrs_q),
    .value    (val_q),
    .post_sel (post_q),
    .busy     (wr_busy),
    .sf_d     (sf_d),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs)
  );

  assign ready  = ready_q;
  assign lcd_rw = 1'b0;

endmodule

// File: doc/lcd_text_responder.md
Name: lcd_text_responder

Overview:
Responder end of the character-display write port driven by the top-level controller. It holds a 32-entry character buffer: 16 chars for line 1 and 16 chars for line 2. It accepts single-cycle writes, returns combinational read-back of the addressed cell, and owns the physical 4-bit HD44780-style LCD bus. After power-up initialisation it refreshes the panel continuously from the buffer. The host never sees panel timing.

Parameters:
T_POWERUP, 750000, cycles to wait after reset before first nibble (15 ms at 50 MHz)
T_INIT_LONG, 205000, wait after first 0x3 init nibble (4.1 ms)
T_INIT_SHORT, 5000, wait after second 0x3 init nibble (100 us)
T_CMD, 2000, wait after every byte except clear (40 us)
T_CLEAR, 82000, wait after clear-display command (1.64 ms)
T_E, 12, lcd_e high width in cycles (240 ns)
T_SETUP, 2, cycles sf_d/lcd_rs stable before lcd_e rises
T_NIB_GAP, 50, cycles between the two nibbles of one byte (1 us)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
write_enable  in  1  write strobe; data is stored at location on each clk edge where high
location  in  5  buffer address: 0-15 is line 1, 16-31 is line 2
data  in  8  character code to write
read_data  out  8  combinational buf[location]
ready  out  1  high once the init sequence has completed
sf_d  out  4  LCD data nibble (panel D7..D4)
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  0 = command, 1 = character data
lcd_rw  out  1  tied 0 (write only)

Behaviour:
- Reset (rst_n low, async): all buffer cells = 0x20; sf_d = 0, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, ready = 0; FSM goes to S_POWERUP; wait counter cleared.
- Reset asserted mid-operation: lcd_e drops immediately and the full init sequence restarts; there is no partial resume.
- Write port:
  - Accepted in every state, including during reset recovery and init; never stalls; no backpressure.
  - read_data reflects a write from the next cycle.
  - Consecutive writes to the same location: last one wins.
- Nibble transfer, done by the sub-module:
  - Drive sf_d and lcd_rs.
  - Wait T_SETUP cycles, then lcd_e = 1 for exactly T_E cycles, then lcd_e = 0.
  - sf_d and lcd_rs are held until lcd_e has been low for 1 cycle.
- Byte transfer: high nibble, then T_NIB_GAP, then low nibble, then the post-byte wait (T_CMD, or T_CLEAR for 0x01).
- Main FSM states:
  - S_POWERUP: wait T_POWERUP.
  - S_INIT: single nibbles with RS = 0:
    - 0x3, then wait T_INIT_LONG
    - 0x3, then wait T_INIT_SHORT
    - 0x3, then wait T_CMD
    - 0x2, then wait T_CMD
  - S_CFG: bytes with RS = 0, in order: 0x28 (function set), 0x06 (entry mode), 0x0C (display on, cursor off), 0x01 (clear, uses T_CLEAR). ready goes 1 on the cycle after the clear wait ends and stays 1 until reset.
  - S_ADDR1: command 0x80, then S_LINE1.
  - S_LINE1: 16 data bytes with RS = 1, buf[0..15], then S_ADDR2.
  - S_ADDR2: command 0xC0, then S_LINE2.
  - S_LINE2: 16 data bytes, buf[16..31], then back to S_ADDR1. The refresh loops forever.
- Refresh character capture:
  - The character is latched from the buffer on the cycle the byte transfer starts.
  - A write to that cell on the same edge or later shows up on the next pass.
  - Worst-case display latency is 2 full passes.
- Wait counter: counts down from parameter - 1 to 0 and never wraps. The refresh index is a 4-bit counter that wraps 15 -> 0 when the line changes.
- lcd_rw is constant 0 and is never toggled.

Decomposition:
- Shared package lcd_pkg:
  - command constants: CMD_FUNC_SET = 0x28, CMD_ENTRY = 0x06, CMD_DISP_ON = 0x0C, CMD_CLEAR = 0x01, CMD_LINE1 = 0x80, CMD_LINE2 = 0xC0
  - CHAR_SPACE = 0x20
  - main FSM state enum
  - LINE_LEN = 16, BUF_DEPTH = 32
- Sub-module lcd_nibble_writer:
  - Inputs: start, byte/nibble mode, rs, value, post-wait select.
  - Outputs: busy, and it drives sf_d, lcd_e, lcd_rs.
  - The main FSM only sequences bytes.

Test Plan:
All parameters are shrunk (e.g. waits 20..200 cycles, T_E = 3).
1. rst_n low, sweep location 0..31 -> read_data = 0x20 everywhere; sf_d = 0, lcd_e = 0, lcd_rs = 0, ready = 0.
2. Release reset, decode lcd_e falling edges -> RS = 0 nibbles 3,3,3,2, then 2,8, 0,6, 0,C, 0,1. Gaps must be at least the programmed waits, and ready = 1 only after the clear wait.
3. After ready, write location 5 = 0x41 -> read_data = 0x41 next cycle. The next pass after 0x80 shows RS = 1 nibbles 4,1 as the 6th character.
4. Write location 17 = 0x5A -> appears as the 2nd data byte after command 0xC0. Line-1 bytes are unchanged (0x20).
5. Drop rst_n while lcd_e = 1 in S_LINE2 -> lcd_e = 0 within the same cycle (async). The buffer reads 0x20 and the init nibble 0x3 reappears after T_POWERUP.
6. Write all 32 locations on consecutive cycles during init -> all read back correct. The first refresh pass emits all 32 values, and every lcd_e pulse is exactly T_E cycles.
